rr_arb_4_1: RTL and testbench



---
 rtl/rr_arb_4_1_pkg.sv | 21 ++
 rtl/rr_arb_4_1_if.sv | 24 ++
 rtl/mux_4_1.sv | 25 ++
 rtl/rr_arb_4_1.sv | 76 +++++++
 tb/tb_rr_arb_4_1.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_4_1_pkg.sv
// Shared types and the rotating-priority pick used by the 4:1 arbiter.
// The round-robin/fixed-priority choice is made by RR_ARB_ROUND_ROBIN_EN in rr_arb_4_1.
package rr_arb_pkg;

  localparam int N_CH = 4;
  localparam int W    = 4;

  typedef logic [W-1:0] data_t;
  typedef logic [1:0]   sel_t;

  // First requester at or above start, modulo 4; returns start when nobody requests.
  function automatic sel_t rr_pick(logic [3:0] req, sel_t start);
    sel_t idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + sel_t'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arb_4_1_if.sv
// Producer-side requests and consumer-side valid/ready word for the 4:1 arbiter.
// slave = arbiter view, master = producers plus consumer.
interface rr_arb_4_1_if;
  import rr_arb_pkg::*;

  logic  [N_CH-1:0] in_valid;
  data_t [N_CH-1:0] in_data;
  logic  [N_CH-1:0] in_ready;
  logic             out_valid;
  data_t            out_data;
  sel_t             out_sel;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_4_1.sv
// 4:1 data mux, 4-bit lanes.
// Latency: combinational. Backpressure: none.
module mux_4_1
  import rr_arb_pkg::*;
(
  input  data_t d0,
  input  data_t d1,
  input  data_t d2,
  input  data_t d3,
  input  sel_t  sel,
  output data_t y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arb_4_1.sv
// 4-channel arbiter into one registered word; round robin with RR_ARB_ROUND_ROBIN_EN, else fixed priority.
// Latency: 1 cycle from grant to out_data. Backpressure: out_ready low freezes the word and drops all in_ready.
module rr_arb_4_1
  import rr_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_4_1_if.slave bus
);

  logic  load;
  logic  gnt_any;
  logic  out_valid_q;
  sel_t  gnt_idx;
  sel_t  scan_start;
  sel_t  out_sel_q;
  data_t out_data_q;
  data_t mux_y;

  assign load    = !out_valid_q || bus.out_ready;
  assign gnt_any = |bus.in_valid;
  assign gnt_idx = rr_pick(bus.in_valid, scan_start);

`ifdef RR_ARB_ROUND_ROBIN_EN
  sel_t ptr;

  // Next scan starts just past the winner; 2-bit add wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load && gnt_any) begin
      ptr <= gnt_idx + 2'd1;
    end
  end

  assign scan_start = ptr;
`else
  assign scan_start = '0;
`endif

  // Gated by rst_n so no channel sees an accept while reset is held.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load && gnt_any) bus.in_ready[gnt_idx] = 1'b1;
  end

  mux_4_1 u_mux (
    .d0  (bus.in_data[0]),
    .d1  (bus.in_data[1]),
    .d2  (bus.in_data[2]),
    .d3  (bus.in_data[3]),
    .sel (gnt_idx),
    .y   (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_y;
        out_sel_q   <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Scoreboard bench for rr_arb_4_1: a reference grant model pushes expected words, consumer handshakes pop them.
// Directed phases cover reset, fairness, backpressure, skip/wrap, drain and mid-run reset, then random traffic.
module tb_rr_arb_4_1;
  import rr_arb_pkg::*;

`ifdef RR_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  sel_t       ref_ptr;
  bit         ref_ov;
  logic [5:0] q[$];
  logic [5:0] last_word;
  logic [1:0] obs_sel[$];
  data_t      obs_dat[$];

  rr_arb_4_1_if bus();

  rr_arb_4_1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    ref_ptr   = 2'd0;
    ref_ov    = 1'b0;
    last_word = 6'd0;
    q.delete();
  endtask

  // Checks one cycle at the falling edge, advances the model, returns 1 time unit after the next rising edge.
  task automatic step();
    bit         load;
    bit         any;
    bit         found;
    sel_t       start;
    sel_t       gi;
    sel_t       idx;
    logic [3:0] exp_rdy;
    logic [5:0] w;
    @(negedge clk);
    load  = !ref_ov || bus.out_ready;
    any   = |bus.in_valid;
    start = RR ? ref_ptr : 2'd0;
    gi    = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = sel_t'((int'(start) + k) % 4);
      if (!found && bus.in_valid[idx]) begin
        gi    = idx;
        found = 1'b1;
      end
    end
    exp_rdy = 4'b0000;
    if (rst_n && load && any) exp_rdy[gi] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(ref_ov));
    if (ref_ov && q.size() > 0)
      check("out_word", 32'({bus.out_sel, bus.out_data}), 32'(q[0]));
    else if (!ref_ov)
      check("hold_word", 32'({bus.out_sel, bus.out_data}), 32'(last_word));
    if (ref_ov && bus.out_ready) begin
      obs_sel.push_back(bus.out_sel);
      obs_dat.push_back(bus.out_data);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (rst_n && load) begin
      if (any) begin
        w = {gi, bus.in_data[gi]};
        q.push_back(w);
        last_word = w;
        ref_ov    = 1'b1;
        ref_ptr   = gi + 2'd1;
      end else begin
        ref_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'hF;
    bus.in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
    bus.out_ready = 1'b1;
    ref_reset();
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_sel", 32'(bus.out_sel), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Fairness: all four requesting, consumer always ready.
    obs_sel.delete();
    obs_dat.delete();
    repeat (9) step();
    check("fair_cnt", 32'(obs_sel.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_sel.size(); i++) begin
      check("fair_sel", 32'(obs_sel[i]), RR ? 32'(i % 4) : 32'd0);
      check("fair_dat", 32'(obs_dat[i]), RR ? 32'(4'hA + i % 4) : 32'hA);
    end

    // Backpressure on a word from channel 2.
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 4'h7;
    step();
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b0;
    repeat (3) begin
      step();
      check("bp_data", 32'(bus.out_data), 32'h7);
      check("bp_sel", 32'(bus.out_sel), 32'd2);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_next_sel", 32'(bus.out_sel), RR ? 32'd3 : 32'd0);

    // Skip and wrap with channels 0 and 2 requesting.
    bus.in_valid = 4'b0100;
    step();
    check("wrap_a", 32'(bus.out_sel), 32'd2);
    bus.in_valid = 4'b0101;
    step();
    check("wrap_b", 32'(bus.out_sel), 32'd0);
    step();
    check("wrap_c", 32'(bus.out_sel), RR ? 32'd2 : 32'd0);
    step();
    check("wrap_d", 32'(bus.out_sel), 32'd0);

    // Idle and drain: one word on channel 1.
    bus.in_valid = 4'b0000;
    step();
    bus.in_valid   = 4'b0010;
    bus.in_data[1] = 4'h9;
    step();
    check("drain_v1", 32'(bus.out_valid), 32'd1);
    check("drain_s1", 32'(bus.out_sel), 32'd1);
    bus.in_valid = 4'b0000;
    step();
    check("drain_v0", 32'(bus.out_valid), 32'd0);
    check("drain_sel", 32'(bus.out_sel), 32'd1);
    check("drain_dat", 32'(bus.out_data), 32'h9);
    step();
    step();

    // Random traffic with withdrawals and backpressure.
    repeat (300) begin
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset while a word is held under backpressure.
    bus.in_valid   = 4'b1000;
    bus.in_data[3] = 4'h5;
    bus.out_ready  = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    check("mrst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_data", 32'(bus.out_data), 32'd0);
    check("mrst_sel", 32'(bus.out_sel), 32'd0);
    ref_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    step();
    check("mrst_first_sel", 32'(bus.out_sel), 32'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
